// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   PS2_EXT / PS2_BRK / PS2_PAUSE : scan-code set 2 prefix bytes
//   PS2_IGNORED                   : controller replies and idle bytes the decoder drops
//   dec_state_e                   : prefix decoder states
//   is_ignored()                  : membership test against PS2_IGNORED
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Pause/Break sends E1 followed by seven more bytes that carry no key info.
   localparam int unsigned PS2_PAUSE_SKIP = 7;

   // Bytes that are keyboard status/ack traffic rather than key codes.
   localparam int unsigned PS2_N_IGNORED = 7;
   localparam logic [7:0] PS2_IGNORED [PS2_N_IGNORED] = '{
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF
   };

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      PAUSE
   } dec_state_e;

   function automatic logic is_ignored(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < PS2_N_IGNORED; i++) begin
         if (b == PS2_IGNORED[i]) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deserializer.
// Latency: byte_vld_o/frame_err_o register 1 clk after the filtered bit-10 falling edge.
// Backpressure: none; byte_vld_o is a one-cycle pulse the consumer must take.
//
// Ports:
//   clk_i, rst_i     : system clock, async active-high reset
//   ps2_clk_i        : raw PS/2 clock line (asynchronous)
//   ps2_data_i       : raw PS/2 data line (asynchronous)
//   byte_o           : last good data byte (held until the next good frame)
//   byte_vld_o       : one-cycle pulse, byte_o is new
//   frame_err_o      : one-cycle pulse on parity or stop-bit failure
//   wd_abort_o       : one-cycle pulse when a stalled frame is abandoned
//
// Optional: define PS2_WATCHDOG_EN to build the mid-frame inactivity watchdog.
module ps2_frame_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_vld_o,
   output logic       frame_err_o,
   output logic       wd_abort_o
);

   localparam int FW = $clog2(FILTER_LEN + 1);

   // Index 0 carries the PS/2 clock, index 1 the PS/2 data.
   logic [1:0]         sync1_q, sync2_q;
   logic [1:0]         filt_q, filt_d;
   logic [1:0][FW-1:0] fcnt_q, fcnt_d;

   logic               clk_fd_q;
   logic               fall;
   logic               data_bit;

   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [8:0]         sr_q, sr_d;
   logic [7:0]         byte_q, byte_d;
   logic               vld_q, vld_d;
   logic               err_q, err_d;

   // ------------------------------------------------------------------
   // Stability filter: a line level is accepted only after FILTER_LEN
   // consecutive synchronized samples disagree with the current filtered
   // level. Any agreeing sample restarts the count, so short glitches die.
   // ------------------------------------------------------------------
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
               filt_d[i] = sync2_q[i];
            end else begin
               fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign fall     = clk_fd_q & ~filt_q[0];
   assign data_bit = filt_q[1];

`ifdef PS2_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   logic          any_edge;
   logic          wd_hit;
   logic [WW-1:0] wd_cnt_q, wd_cnt_d;
   logic          wd_abort_q;

   assign any_edge = clk_fd_q ^ filt_q[0];
   assign wd_hit   = (bit_cnt_q != 4'd0) && !any_edge && (wd_cnt_q == WW'(TIMEOUT_CYC));

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (bit_cnt_q == 4'd0 || any_edge || wd_hit) begin
         wd_cnt_d = '0;
      end else begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_cnt_q   <= '0;
         wd_abort_q <= 1'b0;
      end else begin
         wd_cnt_q   <= wd_cnt_d;
         wd_abort_q <= wd_hit;
      end
   end

   assign wd_abort_o = wd_abort_q;
`else
   assign wd_abort_o = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Deserializer: bit 0 start, bits 1-8 data LSB first, bit 9 odd
   // parity, bit 10 stop. A high "start bit" is line noise or a stray
   // edge and is dropped without leaving the idle position.
   // ------------------------------------------------------------------
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      byte_d    = byte_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      if (fall) begin
         if (bit_cnt_q == 4'd0) begin
            if (!data_bit) begin
               bit_cnt_d = 4'd1;
            end
         end else if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            // XOR over data+parity is 1 exactly when parity is odd.
            if ((^sr_q) && data_bit) begin
               vld_d  = 1'b1;
               byte_d = sr_q[7:0];
            end else begin
               err_d = 1'b1;
            end
         end else begin
            sr_d      = {data_bit, sr_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end
`ifdef PS2_WATCHDOG_EN
      if (wd_hit) begin
         bit_cnt_d = 4'd0;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q   <= 2'b11;
         sync2_q   <= 2'b11;
         filt_q    <= 2'b11;
         fcnt_q    <= '0;
         clk_fd_q  <= 1'b1;
         bit_cnt_q <= 4'd0;
         sr_q      <= '0;
         byte_q    <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync1_q   <= {ps2_data_i, ps2_clk_i};
         sync2_q   <= sync1_q;
         filt_q    <= filt_d;
         fcnt_q    <= fcnt_d;
         clk_fd_q  <= filt_q[0];
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         byte_q    <= byte_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
      end
   end

   assign byte_o      = byte_q;
   assign byte_vld_o  = vld_q;
   assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to ps2_key event word: filters/deserializes frames and collapses set-2 prefixes.
// Latency: ps2_key/key_strobe update 2 clk_sys after the filtered bit-10 falling edge.
// Backpressure: none; each key_strobe is a one-cycle pulse and ps2_key holds until the next event.
//
// Ports:
//   clk_sys      : system clock (12 MHz nominal)
//   RESET        : async active-high reset
//   ps2_clk_in   : raw PS/2 clock line
//   ps2_data_in  : raw PS/2 data line
//   ps2_key      : [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   key_strobe   : one-cycle pulse with every ps2_key update
//   frame_err    : one-cycle pulse on parity or stop-bit error
//
// Optional: define PS2_WATCHDOG_EN to abandon frames stalled for TIMEOUT_CYC cycles.
module ps2_key_encoder #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic [10:0] ps2_key,
   output logic        key_strobe,
   output logic        frame_err
);

   import ps2_pkg::*;

   logic [7:0] rx_byte;
   logic       rx_vld;
   logic       rx_err;
   logic       wd_abort;

   dec_state_e state_q;
   logic [2:0] skip_q;
   logic [10:0] key_q;
   logic       strobe_q;

   ps2_frame_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk_i       (clk_sys),
      .rst_i       (RESET),
      .ps2_clk_i   (ps2_clk_in),
      .ps2_data_i  (ps2_data_in),
      .byte_o      (rx_byte),
      .byte_vld_o  (rx_vld),
      .frame_err_o (rx_err),
      .wd_abort_o  (wd_abort)
   );

   // ------------------------------------------------------------------
   // Prefix decoder. One step per good byte; the emitted event carries
   // the prefix context accumulated in the state. The toggle bit lets a
   // consumer on a slower clock detect a new event without the strobe.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         skip_q   <= 3'd0;
         key_q    <= 11'h000;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         if (wd_abort) begin
            state_q <= IDLE;
            skip_q  <= 3'd0;
         end else if (rx_vld) begin
            case (state_q)
               IDLE: begin
                  if (rx_byte == PS2_EXT) begin
                     state_q <= EXT;
                  end else if (rx_byte == PS2_BRK) begin
                     state_q <= BRK;
                  end else if (rx_byte == PS2_PAUSE) begin
                     state_q <= PAUSE;
                     skip_q  <= 3'(PS2_PAUSE_SKIP);
                  end else if (!is_ignored(rx_byte)) begin
                     key_q    <= {~key_q[10], 1'b1, 1'b0, rx_byte};
                     strobe_q <= 1'b1;
                  end
               end
               EXT: begin
                  if (rx_byte == PS2_BRK) begin
                     state_q <= EXT_BRK;
                  end else begin
                     key_q    <= {~key_q[10], 1'b1, 1'b1, rx_byte};
                     strobe_q <= 1'b1;
                     state_q  <= IDLE;
                  end
               end
               BRK: begin
                  key_q    <= {~key_q[10], 1'b0, 1'b0, rx_byte};
                  strobe_q <= 1'b1;
                  state_q  <= IDLE;
               end
               EXT_BRK: begin
                  key_q    <= {~key_q[10], 1'b0, 1'b1, rx_byte};
                  strobe_q <= 1'b1;
                  state_q  <= IDLE;
               end
               PAUSE: begin
                  // Pause/Break has no release; its tail bytes are swallowed.
                  skip_q <= skip_q - 3'd1;
                  if (skip_q == 3'd1) begin
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign ps2_key    = key_q;
   assign key_strobe = strobe_q;
   assign frame_err  = rx_err;

endmodule
